// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, special encodings and sequencer state for the adder front-end.
package fp16_pkg;
  localparam int SIGN   = 15;
  localparam int EXP_HI = 14;
  localparam int EXP_LO = 10;
  localparam int MAN_HI = 9;

  localparam logic [4:0]  EXP_MAX  = 5'd31;
  localparam logic [15:0] QNAN_DEF = 16'h7E00;
  localparam logic [15:0] POS_INF  = 16'h7C00;
  localparam logic [15:0] NEG_INF  = 16'hFC00;

  typedef enum logic [2:0] {
    IDLE,
    CLASS,
    ADD,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic inv;
    logic ovf;
    logic unf;
    logic zero;
  } flags_t;
endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 operand classifier; with FTZ any exp==0 encoding counts as zero.
module fp16_classify
  import fp16_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic [15:0] x,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        sign,
  output logic [4:0]  exp
);
  logic man_nz;

  assign exp     = x[EXP_HI:EXP_LO];
  assign sign    = x[SIGN];
  assign man_nz  = |x[MAN_HI:0];
  assign is_nan  = (exp == EXP_MAX) && man_nz;
  assign is_inf  = (exp == EXP_MAX) && !man_nz;
  assign is_zero = (exp == 5'd0) && (FTZ || !man_nz);
endmodule

// File: rtl/fp16_add_sequencer.sv
// Multicycle front-end for an external combinational fp16 adder: resolves special
// operands locally, feeds the adder magnitude-ordered operands and post-checks its sum.
module fp16_add_sequencer
  import fp16_pkg::*;
#(
  parameter logic [15:0] QNAN = QNAN_DEF,
  parameter bit          FTZ  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_inv,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_zero,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum
);
  state_t state, state_nx;
  logic [15:0] a_q, b_q, sum_q;
  flags_t flags;

  logic [1:0][15:0] ops;
  logic [1:0]       nan, inf, zero, sgn;
  logic [1:0][4:0]  ex;

  assign ops = {b_q, a_q};

  for (genvar i = 0; i < 2; i++) begin : g_cls
    fp16_classify #(.FTZ(FTZ)) u_cls (
      .x(ops[i]), .is_nan(nan[i]), .is_inf(inf[i]),
      .is_zero(zero[i]), .sign(sgn[i]), .exp(ex[i])
    );
  end

  logic        byp;
  logic [15:0] byp_res;
  flags_t      byp_flags;

  always_comb begin
    byp       = 1'b1;
    byp_res   = 16'h0000;
    byp_flags = '0;
    if (|nan) begin
      byp_res       = QNAN;
      byp_flags.inv = 1'b1;
    end else if ((&inf) && (sgn[0] != sgn[1])) begin
      byp_res       = QNAN;
      byp_flags.inv = 1'b1;
    end else if (inf[0]) begin
      byp_res = a_q;
    end else if (inf[1]) begin
      byp_res = b_q;
    end else if (&zero) begin
      byp_res        = {&sgn, 15'b0};
      byp_flags.zero = 1'b1;
    end else if (zero[0]) begin
      byp_res = b_q;
    end else if (zero[1]) begin
      byp_res = a_q;
    end else begin
      byp = 1'b0;
    end
  end

  // A cancelling subtract can wrap the adder's exponent below zero, which shows up
  // as an exponent far above what the operands could produce.
  logic [4:0]  e_s, emax;
  logic        s_s;
  logic [15:0] chk_res;
  flags_t      chk_flags;

  assign e_s  = sum_q[EXP_HI:EXP_LO];
  assign s_s  = sum_q[SIGN];
  assign emax = (ex[0] > ex[1]) ? ex[0] : ex[1];

  always_comb begin
    chk_res   = sum_q;
    chk_flags = '0;
    if (sum_q == 16'h0000) begin
      chk_res        = 16'h0000;
      chk_flags.zero = 1'b1;
    end else if ({1'b0, e_s} > ({1'b0, emax} + 6'd1)) begin
      chk_res        = {s_s, 15'b0};
      chk_flags.unf  = 1'b1;
      chk_flags.zero = 1'b1;
    end else if (e_s == EXP_MAX) begin
      chk_res       = {s_s, EXP_MAX, 10'h000};
      chk_flags.ovf = 1'b1;
    end else if (e_s == 5'd0) begin
      chk_res        = {s_s, 15'b0};
      chk_flags.unf  = 1'b1;
      chk_flags.zero = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLASS;
      CLASS:   state_nx = byp ? DONE : ADD;
      ADD:     state_nx = CHECK;
      CHECK:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      sum_q  <= 16'h0000;
      add_a  <= 16'h0000;
      add_b  <= 16'h0000;
      result <= 16'h0000;
      flags  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          flags <= '0;
        end
        CLASS: if (byp) begin
          result <= byp_res;
          flags  <= byp_flags;
        end else if (a_q[EXP_HI:0] >= b_q[EXP_HI:0]) begin
          add_b <= a_q;
          add_a <= b_q;
        end else begin
          add_b <= b_q;
          add_a <= a_q;
        end
        ADD:   sum_q <= add_sum;
        CHECK: begin
          result <= chk_res;
          flags  <= chk_flags;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign flag_inv  = flags.inv;
  assign flag_ovf  = flags.ovf;
  assign flag_unf  = flags.unf;
  assign flag_zero = flags.zero;
endmodule
